// File: rtl/sync_debounce_pkg.sv
// ============================================================================
//  Module      : sync_debounce_pkg
//  Description : Shared types, defaults and width helper for the sync_debounce
//                input-conditioning block.
//                  state_t          - qualification FSM states (IDLE, CHECK)
//                  cnt_width()      - stability counter width for a given
//                                     STABLE_CYCLES value
//                  DEFAULT_*        - default parameter values
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_debounce_pkg;

    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_STABLE_CYCLES = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    // The counter only ever reaches STABLE_CYCLES-1, but sizing for
    // STABLE_CYCLES+1 keeps the width at least 1 bit when STABLE_CYCLES==1.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage : sync_debounce_pkg

`default_nettype wire

// File: rtl/sync_debounce_sync_chain.sv
// ============================================================================
//  Module      : sync_chain
//  Description : Multi-flop synchronizer for a single asynchronous level.
//                Synchronous active-high reset clears every stage to 0.
//  Ports       : clk - clock
//                rst - synchronous active-high reset
//                d   - asynchronous input level
//                q   - synchronized level (last stage)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_chain: STAGES must be >= 2");
    end

    logic [STAGES-1:0] r_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
        end else begin
            r_sr <= {r_sr[STAGES-2:0], d};
        end
    end

    assign q = r_sr[STAGES-1];

endmodule : sync_chain

`default_nettype wire

// File: rtl/sync_debounce.sv
// ============================================================================
//  Module      : sync_debounce
//  Description : Synchronizes a raw asynchronous level and only lets the
//                output follow a change once the synchronized level has held
//                for STABLE_CYCLES consecutive enabled clocks. Produces
//                registered one-cycle rise/fall pulses aligned with dout.
//  Ports       : clk  - clock, all state updates on the rising edge
//                rst  - synchronous active-high reset
//                din  - raw asynchronous level
//                en   - filter enable (0 freezes dout and aborts qualifying)
//                dout - debounced registered level
//                rise - one-cycle pulse on dout 0->1
//                fall - one-cycle pulse on dout 1->0
//                busy - high while a candidate change is being qualified
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("sync_debounce: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
        $error("sync_debounce: STABLE_CYCLES must be >= 1");
    end

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic          w_din_s;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_dout;
    logic          w_dout_nxt;
    logic          r_rise;
    logic          r_fall;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (w_din_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_dout  <= w_dout_nxt;
            // Pulses are derived from the same next-value that updates
            // dout, so they land in exactly the cycle dout changes.
            r_rise  <= w_dout_nxt & ~r_dout;
            r_fall  <= ~w_dout_nxt & r_dout;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_dout_nxt  = r_dout;

        if (!en) begin
            // Disabling aborts any qualification in progress; re-enabling
            // restarts from zero.
            w_state_nxt = IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_din_s != r_dout) begin
                        if (STABLE_CYCLES == 1) begin
                            // A single stable cycle is enough: accept now.
                            w_dout_nxt  = w_din_s;
                            w_count_nxt = '0;
                        end else begin
                            w_state_nxt = CHECK;
                            w_count_nxt = C_ONE;
                        end
                    end
                end
                CHECK: begin
                    if (w_din_s == r_dout) begin
                        // Level went back before qualifying: glitch.
                        w_state_nxt = IDLE;
                        w_count_nxt = '0;
                    end else if (r_count == C_LAST) begin
                        w_dout_nxt  = w_din_s;
                        w_state_nxt = IDLE;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count + C_ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = (r_state == CHECK);

endmodule : sync_debounce

`default_nettype wire

// File: tb/tb_sync_debounce.sv
// ============================================================================
//  Module      : tb_sync_debounce
//  Description : Self-checking bench for sync_debounce (default parameters).
//                A run-length reference model predicts dout/rise/fall/busy
//                after every clock edge; directed scenarios are followed by
//                a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_debounce;

    localparam int SS = 2;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic en;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    int tests = 0;
    int fails = 0;

    // Reference model: din history and the length of the current run of
    // enabled cycles in which the synchronized level differs from dout.
    logic m_sh [SS];
    logic m_dout = 1'b0;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    int   m_run  = 0;

    sync_debounce #(
        .SYNC_STAGES   (SS),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .en   (en),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, advance the model at the rising
    // edge, compare shortly after it.
    task automatic step(input logic d, input logic e, input logic r);
        logic s;
        @(negedge clk);
        din = d;
        en  = e;
        rst = r;
        @(posedge clk);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (r) begin
            for (int i = 0; i < SS; i++) m_sh[i] = 1'b0;
            m_dout = 1'b0;
            m_run  = 0;
        end else begin
            s = m_sh[SS-1];
            for (int i = SS - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
            m_sh[0] = d;
            if (!e || s == m_dout) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == SC) begin
                    m_rise = s;
                    m_fall = ~s;
                    m_dout = s;
                    m_run  = 0;
                end
            end
        end
        #2;
        check_bit("dout", dout, m_dout);
        check_bit("rise", rise, m_rise);
        check_bit("fall", fall, m_fall);
        check_bit("busy", busy, m_run != 0);
    endtask

    // Hold din at d (enabled) for up to n clocks; return the 1-based index of
    // the clock on which the matching edge pulse appeared, -1 if none.
    task automatic measure(input logic d, input int n, output int k_hit);
        k_hit = -1;
        for (int k = 1; k <= n; k++) begin
            step(d, 1'b1, 1'b0);
            if ((d ? rise : fall) && k_hit < 0) k_hit = k;
        end
    endtask

    initial begin
        int k_hit;
        int n_rise;
        int n_fall;
        logic rd;
        logic re;
        int hold;

        for (int i = 0; i < SS; i++) m_sh[i] = 1'b0;
        din = 1'b1;
        en  = 1'b1;
        rst = 1'b1;

        // Reset held with din=1: outputs stay 0.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);

        // Release: edge 1 is the capture edge, dout rises SS+SC-1 edges later.
        measure(1'b1, 10, k_hit);
        check_int("reset_release_latency", k_hit, SS + SC);

        // Clean steps in both directions.
        measure(1'b0, 10, k_hit);
        check_int("clean_fall_latency", k_hit, SS + SC);
        measure(1'b1, 10, k_hit);
        check_int("clean_rise_latency", k_hit, SS + SC);
        measure(1'b0, 10, k_hit);
        check_int("clean_fall_latency2", k_hit, SS + SC);

        // Glitch: high for SC-1 cycles must be rejected.
        n_rise = 0;
        for (int i = 0; i < SC - 1; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (rise) n_rise++;
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (rise) n_rise++;
        end
        check_int("glitch_rises", n_rise, 0);

        // Boundary: high for exactly SC cycles qualifies, then falls back.
        n_rise = 0;
        n_fall = 0;
        for (int i = 0; i < SC; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (rise) n_rise++;
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (rise) n_rise++;
            if (fall) n_fall++;
        end
        check_int("boundary_rises", n_rise, 1);
        check_int("boundary_falls", n_fall, 1);

        // Enable dropped in the 2nd CHECK cycle, then restored.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check_bit("en_off_dout", dout, 1'b0);
        measure(1'b1, 10, k_hit);
        check_int("reenable_latency", k_hit, SC);

        // Reset while qualifying (count == 2), then recovery with din=1.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        check_bit("pre_reset_busy", busy, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        measure(1'b1, 12, k_hit);
        check_int("post_reset_latency", k_hit, SS + SC);

        // Randomized runs of varying length with occasional disable/reset.
        for (int blk = 0; blk < 150; blk++) begin
            rd   = 1'($urandom_range(0, 1));
            re   = ($urandom_range(0, 7) != 0);
            hold = $urandom_range(1, 7);
            for (int j = 0; j < hold; j++) begin
                step(rd, re, (j == 0) && ($urandom_range(0, 40) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sync_debounce

`default_nettype wire

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Input-conditioning stage that sits directly upstream of the team's synchronous D flip-flop (dff_syn) and produces the clean data it consumes.
- Takes a raw, asynchronously toggling level and passes it through an N-stage synchronizer. It then accepts a level change only after it has held for STABLE_CYCLES consecutive clocks.
- Outputs the filtered level plus single-cycle rise/fall pulses. dout drives dff_syn.d.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (legal: >= 2).
- STABLE_CYCLES, 4, consecutive cycles a changed synchronized level must persist before dout follows (legal: >= 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  raw asynchronous level.
- en  input  1  filter enable.
- dout  output  1  debounced, registered level.
- rise  output  1  one-cycle pulse on a 0->1 change of dout.
- fall  output  1  one-cycle pulse on a 1->0 change of dout.
- busy  output  1  high while a candidate change is being qualified.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled on the clk rising edge.
- Reset values:
  - all synchronizer stages = 0, count = 0, state = IDLE.
  - dout = 0, rise = 0, fall = 0, busy = 0.
  - Values hold from the first edge with rst=1 through the edge after rst deasserts.
- Reset priority: rst overrides en and every other condition. Reset mid-qualification aborts it with no pulse.
- Synchronizer:
  - din shifts through SYNC_STAGES flops; din_s = last stage.
  - It runs regardless of en.
- Counter width: CW = $clog2(STABLE_CYCLES+1). count never exceeds STABLE_CYCLES-1.
- State machine:
  - IDLE: din_s == dout.
    - If en=1 and din_s != dout: if STABLE_CYCLES==1, update dout this edge and stay IDLE. Otherwise go to CHECK with count = 1.
  - CHECK: busy = 1.
    - din_s == dout: glitch rejected, go to IDLE, count = 0, no pulse.
    - din_s != dout and count == STABLE_CYCLES-1: dout <= din_s, pulse, go to IDLE, count = 0.
    - Otherwise: count = count + 1.
- Latency: din captured by stage 1 at edge E0 makes dout change at edge E0 + SYNC_STAGES + STABLE_CYCLES - 1. With defaults that is E0+5.
- Pulses: rise/fall are registered and asserted in the same cycle dout changes, for exactly one cycle. They are never both high.
- en=0:
  - state forced to IDLE, count = 0, busy = 0.
  - dout frozen, no pulses.
  - On re-enable, qualification restarts from count 0.
- Changes during the decision edge: a din_s change at the final count compare uses the value sampled at that edge. There is no partial credit.
- Reset with din=1: after release, dout rises at the normal latency with a rise pulse. This is intended behaviour.
- Elaboration error if SYNC_STAGES < 2 or STABLE_CYCLES < 1.

Decomposition:
- Package sync_debounce_pkg:
  - state enum {IDLE, CHECK}.
  - width helper function for CW.
  - default parameter constants.
- Sub-module sync_chain:
  - parameter STAGES.
  - ports clk, rst, d, q.
  - synchronous active-high reset to 0; reused elsewhere for other async inputs.
- Top-level holds the FSM, counter and output registers.

Test Plan:
- Defaults: SYNC_STAGES=2, STABLE_CYCLES=4, 1 ns clock.
- Reset: rst=1 for 3 edges with din=1.
  - During reset: dout=rise=fall=busy=0.
  - After release: stage 1 captures at R, dout=1 at edge R+5, rise=1 for that single cycle.
- Clean step: din 0->1 captured at E0 and held 10 cycles.
  - busy=1 for cycles E0+2..E0+4, dout=1 at E0+5, rise one cycle, fall stays 0.
  - Then din 1->0 gives fall at the same latency.
- Glitch reject: din high for 3 cycles, then low.
  - busy pulses 3 cycles, dout stays 0, no rise.
- Boundary: din high exactly 4 cycles.
  - dout rises at E0+5.
  - Later the low level qualifies and dout falls 4 cycles after din_s drops.
- Enable: en=0 at the 2nd cycle of CHECK while din stays 1.
  - busy=0 next cycle, dout holds 0.
  - en=1 again: dout rises exactly 4 cycles after re-enable.
- Reset mid-CHECK: rst=1 at count=2.
  - Next edge: all outputs 0, state IDLE, no pulse.
  - After release with din=1: rise after full latency.
